// File: rtl/mar_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : mar_addr_gen_if
// Description : Command/handshake bundle between the control unit, the MAR
//               address generator and the DRAM address port.
// Revision    : 1.0
// ============================================================================
interface mar_addr_gen_if #(
    parameter int ADDR_W = 16
);
    logic [2:0]        mar_ctrl;
    logic [ADDR_W-1:0] ac_in;
    logic              mem_ack;
    logic [ADDR_W-1:0] mar_out;
    logic              mar_valid;
    logic              cmd_drop;

    // Control unit / DRAM side
    modport master (
        output mar_ctrl,
        output ac_in,
        output mem_ack,
        input  mar_out,
        input  mar_valid,
        input  cmd_drop
    );

    // Address generator side
    modport slave (
        input  mar_ctrl,
        input  ac_in,
        input  mem_ack,
        output mar_out,
        output mar_valid,
        output cmd_drop
    );
endinterface
`default_nettype wire

// File: rtl/mar_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : mar_addr_gen
// Description : Memory address register with raster read/write pointers and
//               a valid/ack handshake toward DRAM.
// Revision    : 1.0
// ============================================================================
module mar_addr_gen #(
    parameter int ADDR_W    = 16,
    parameter int ROW_W     = 8,
    parameter int COL_W     = 7,
    parameter int RD_STRIDE = 2
) (
    input  wire logic            clock,
    input  wire logic            reset_n,
    mar_addr_gen_if.slave        bus,
    input  wire logic [COL_W:0]  src_cols,
    input  wire logic [ROW_W:0]  src_rows,
    input  wire logic [COL_W:0]  dst_cols,
    input  wire logic [ROW_W:0]  dst_rows,
    output logic                 rd_done,
    output logic                 wr_done
);

    localparam logic [2:0] c_CMD_HOLD   = 3'b000;
    localparam logic [2:0] c_CMD_AC     = 3'b001;
    localparam logic [2:0] c_CMD_RD     = 3'b010;
    localparam logic [2:0] c_CMD_WR     = 3'b011;
    localparam logic [2:0] c_CMD_RD_ADV = 3'b100;
    localparam logic [2:0] c_CMD_WR_ADV = 3'b101;
    localparam logic [2:0] c_CMD_CLR    = 3'b110;

    // Sums are two bits wider than the pointers so a step never wraps silently
    localparam logic [COL_W+1:0] c_RD_CSTEP = (COL_W+2)'(RD_STRIDE);
    localparam logic [ROW_W+1:0] c_RD_RSTEP = (ROW_W+2)'(RD_STRIDE);
    localparam logic [COL_W+1:0] c_WR_CSTEP = (COL_W+2)'(1);
    localparam logic [ROW_W+1:0] c_WR_RSTEP = (ROW_W+2)'(1);

    logic [ROW_W-1:0]  r_rd_row, r_wr_row;
    logic [COL_W-1:0]  r_rd_col, r_wr_col;
    logic [ADDR_W-1:0] r_mar;
    logic              r_valid;
    logic              r_rd_done, r_wr_done;
    logic              r_cmd_drop;

    logic              w_ready, w_is_load, w_accept;
    logic [ADDR_W-1:0] w_load_addr;
    logic [COL_W+1:0]  w_rd_col_sum, w_wr_col_sum;
    logic [ROW_W+1:0]  w_rd_row_sum, w_wr_row_sum;
    logic              w_rd_col_wrap, w_rd_row_wrap;
    logic              w_wr_col_wrap, w_wr_row_wrap;

    assign w_ready   = ~r_valid | bus.mem_ack;
    assign w_is_load = (bus.mar_ctrl != c_CMD_HOLD) && (bus.mar_ctrl <= c_CMD_WR_ADV);
    assign w_accept  = w_is_load & w_ready;

    assign w_rd_col_sum  = {2'b00, r_rd_col} + c_RD_CSTEP;
    assign w_rd_row_sum  = {2'b00, r_rd_row} + c_RD_RSTEP;
    assign w_wr_col_sum  = {2'b00, r_wr_col} + c_WR_CSTEP;
    assign w_wr_row_sum  = {2'b00, r_wr_row} + c_WR_RSTEP;
    assign w_rd_col_wrap = w_rd_col_sum >= {1'b0, src_cols};
    assign w_rd_row_wrap = w_rd_row_sum >= {1'b0, src_rows};
    assign w_wr_col_wrap = w_wr_col_sum >= {1'b0, dst_cols};
    assign w_wr_row_wrap = w_wr_row_sum >= {1'b0, dst_rows};

    always_comb begin
        w_load_addr = r_mar;
        case (bus.mar_ctrl)
            c_CMD_AC:                  w_load_addr = bus.ac_in;
            c_CMD_RD, c_CMD_RD_ADV:    w_load_addr = ADDR_W'({r_rd_row, r_rd_col});
            c_CMD_WR, c_CMD_WR_ADV:    w_load_addr = ADDR_W'({r_wr_row, r_wr_col});
            default:                   w_load_addr = r_mar;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mar      <= '0;
            r_valid    <= 1'b0;
            r_cmd_drop <= 1'b0;
            r_rd_row   <= '0;
            r_rd_col   <= '0;
            r_wr_row   <= '0;
            r_wr_col   <= '0;
            r_rd_done  <= 1'b0;
            r_wr_done  <= 1'b0;
        end else begin
            r_cmd_drop <= w_is_load & ~w_ready;

            if (w_accept) begin
                r_mar   <= w_load_addr;
                r_valid <= 1'b1;
            end else if (bus.mem_ack) begin
                r_valid <= 1'b0;
            end

            if (bus.mar_ctrl == c_CMD_CLR) begin
                r_rd_row  <= '0;
                r_rd_col  <= '0;
                r_wr_row  <= '0;
                r_wr_col  <= '0;
                r_rd_done <= 1'b0;
                r_wr_done <= 1'b0;
            end else if (w_accept && bus.mar_ctrl == c_CMD_RD_ADV) begin
                if (!w_rd_col_wrap) begin
                    r_rd_col <= w_rd_col_sum[COL_W-1:0];
                end else begin
                    r_rd_col <= '0;
                    if (!w_rd_row_wrap) begin
                        r_rd_row <= w_rd_row_sum[ROW_W-1:0];
                    end else begin
                        r_rd_row  <= '0;
                        r_rd_done <= 1'b1;
                    end
                end
            end else if (w_accept && bus.mar_ctrl == c_CMD_WR_ADV) begin
                if (!w_wr_col_wrap) begin
                    r_wr_col <= w_wr_col_sum[COL_W-1:0];
                end else begin
                    r_wr_col <= '0;
                    if (!w_wr_row_wrap) begin
                        r_wr_row <= w_wr_row_sum[ROW_W-1:0];
                    end else begin
                        r_wr_row  <= '0;
                        r_wr_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.mar_out   = r_mar;
    assign bus.mar_valid = r_valid;
    assign bus.cmd_drop  = r_cmd_drop;
    assign rd_done       = r_rd_done;
    assign wr_done       = r_wr_done;

endmodule
`default_nettype wire

// File: tb/tb_mar_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mar_addr_gen
// Description : Directed and randomized checks of mar_addr_gen against a
//               plain-arithmetic reference model.
// Revision    : 1.0
// ============================================================================
module tb_mar_addr_gen;

    localparam int ADDR_W    = 16;
    localparam int ROW_W     = 8;
    localparam int COL_W     = 7;
    localparam int RD_STRIDE = 2;

    logic             clock;
    logic             reset_n;
    logic [COL_W:0]   src_cols, dst_cols;
    logic [ROW_W:0]   src_rows, dst_rows;
    logic             rd_done, wr_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_mar, m_valid, m_drop, m_rd_done, m_wr_done;
    int m_rd_row, m_rd_col, m_wr_row, m_wr_col;

    mar_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

    mar_addr_gen #(
        .ADDR_W   (ADDR_W),
        .ROW_W    (ROW_W),
        .COL_W    (COL_W),
        .RD_STRIDE(RD_STRIDE)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .src_cols(src_cols),
        .src_rows(src_rows),
        .dst_cols(dst_cols),
        .dst_rows(dst_rows),
        .rd_done (rd_done),
        .wr_done (wr_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pack(input int row, input int col);
        return (row * (1 << COL_W) + col) % (1 << ADDR_W);
    endfunction

    task automatic model_reset();
        m_mar = 0; m_valid = 0; m_drop = 0; m_rd_done = 0; m_wr_done = 0;
        m_rd_row = 0; m_rd_col = 0; m_wr_row = 0; m_wr_col = 0;
    endtask

    // Applies the spec rules for one rising edge using the inputs held across it
    task automatic model_edge();
        int  ctrl;
        bit  rdy, ld;
        ctrl = int'(bus.mar_ctrl);
        rdy  = (m_valid == 0) || bus.mem_ack;
        ld   = (ctrl >= 1) && (ctrl <= 5);
        m_drop = (ld && !rdy) ? 1 : 0;
        if (ld && rdy) begin
            if (ctrl == 1)                   m_mar = int'(bus.ac_in);
            else if (ctrl == 2 || ctrl == 4) m_mar = pack(m_rd_row, m_rd_col);
            else                             m_mar = pack(m_wr_row, m_wr_col);
            m_valid = 1;
            if (ctrl == 4) begin
                if (m_rd_col + RD_STRIDE < int'(src_cols)) m_rd_col += RD_STRIDE;
                else begin
                    m_rd_col = 0;
                    if (m_rd_row + RD_STRIDE < int'(src_rows)) m_rd_row += RD_STRIDE;
                    else begin m_rd_row = 0; m_rd_done = 1; end
                end
            end
            if (ctrl == 5) begin
                if (m_wr_col + 1 < int'(dst_cols)) m_wr_col += 1;
                else begin
                    m_wr_col = 0;
                    if (m_wr_row + 1 < int'(dst_rows)) m_wr_row += 1;
                    else begin m_wr_row = 0; m_wr_done = 1; end
                end
            end
        end else if (bus.mem_ack) begin
            m_valid = 0;
        end
        if (ctrl == 6) begin
            m_rd_row = 0; m_rd_col = 0; m_wr_row = 0; m_wr_col = 0;
            m_rd_done = 0; m_wr_done = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".mar_out"},   32'(bus.mar_out),   32'(m_mar));
        check({tag, ".mar_valid"}, 32'(bus.mar_valid), 32'(m_valid));
        check({tag, ".cmd_drop"},  32'(bus.cmd_drop),  32'(m_drop));
        check({tag, ".rd_done"},   32'(rd_done),       32'(m_rd_done));
        check({tag, ".wr_done"},   32'(wr_done),       32'(m_wr_done));
    endtask

    task automatic step(input string tag, input logic [2:0] ctrl,
                        input logic [ADDR_W-1:0] ac, input logic ack);
        bus.mar_ctrl = ctrl;
        bus.ac_in    = ac;
        bus.mem_ack  = ack;
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        int er[7];
        int ec[7];
        int wr_r[7];
        int wr_c[7];
        logic [2:0] rc;
        er   = '{0, 0, 0, 2, 2, 2, 0};
        ec   = '{0, 2, 4, 0, 2, 4, 0};
        wr_r = '{0, 0, 0, 1, 1, 1, 0};
        wr_c = '{0, 1, 2, 0, 1, 2, 0};

        reset_n = 1'b0;
        bus.mar_ctrl = 3'b000; bus.ac_in = '0; bus.mem_ack = 1'b0;
        src_cols = 8'd6; src_rows = 9'd4; dst_cols = 8'd3; dst_rows = 9'd2;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Build some state, then pull reset asynchronously mid-cycle
        step("pre_rst_a", 3'b001, 16'hA5A5, 1'b0);
        step("pre_rst_b", 3'b100, 16'h0000, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        step("post_rst_rd", 3'b010, 16'h0000, 1'b0);
        check("post_rst_mar", 32'(bus.mar_out), 32'h0);
        check("post_rst_vld", 32'(bus.mar_valid), 32'h1);

        // Raster read over a 6x4 source
        step("clr_r", 3'b110, 16'h0000, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step("raster", 3'b100, 16'h0000, 1'b1);
            check("raster_addr", 32'(bus.mar_out), 32'(pack(er[i], ec[i])));
            check("raster_done", 32'(rd_done), (i >= 5) ? 32'h1 : 32'h0);
        end

        // Write pointer over a 3x2 destination
        for (int i = 0; i < 7; i++) begin
            step("wraster", 3'b101, 16'h0000, 1'b1);
            check("wraster_addr", 32'(bus.mar_out), 32'(pack(wr_r[i], wr_c[i])));
        end
        check("wr_done_set", 32'(wr_done), 32'h1);
        step("clr_w", 3'b110, 16'h0000, 1'b1);
        check("wr_done_clr", 32'(wr_done), 32'h0);
        step("wr_after_clr", 3'b011, 16'h0000, 1'b1);
        check("wr_after_clr_addr", 32'(bus.mar_out), 32'h0);

        // Handshake stall
        step("drain", 3'b000, 16'h0000, 1'b1);
        step("stall_ld", 3'b001, 16'hBEEF, 1'b0);
        step("stall_drop", 3'b011, 16'h0000, 1'b0);
        check("stall_mar", 32'(bus.mar_out), 32'hBEEF);
        check("stall_drop_pulse", 32'(bus.cmd_drop), 32'h1);
        step("stall_ack", 3'b000, 16'h0000, 1'b1);
        check("stall_drop_low", 32'(bus.cmd_drop), 32'h0);
        check("stall_vld_clr", 32'(bus.mar_valid), 32'h0);

        // Load coincident with ack
        step("co_ld", 3'b001, 16'h5555, 1'b0);
        step("co_ack", 3'b001, 16'h1234, 1'b1);
        check("co_mar", 32'(bus.mar_out), 32'h1234);
        check("co_vld", 32'(bus.mar_valid), 32'h1);
        check("co_drop", 32'(bus.cmd_drop), 32'h0);

        // Column pointer at the top of a 128-wide row
        src_cols = 8'd128; src_rows = 9'd256;
        step("edge_clr", 3'b110, 16'h0000, 1'b1);
        for (int i = 0; i < 63; i++) step("edge_walk", 3'b100, 16'h0000, 1'b1);
        step("edge_last", 3'b100, 16'h0000, 1'b1);
        check("edge_last_addr", 32'(bus.mar_out), 32'(pack(0, 126)));
        step("edge_next", 3'b010, 16'h0000, 1'b1);
        check("edge_next_addr", 32'(bus.mar_out), 32'(pack(2, 0)));

        // Randomized traffic with occasional limit changes
        src_cols = 8'd5; src_rows = 9'd5; dst_cols = 8'd4; dst_rows = 9'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                src_cols = 8'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 128 : 9));
                src_rows = 9'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 256 : 9));
                dst_cols = 8'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 128 : 9));
                dst_rows = 9'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 256 : 9));
            end
            rc = 3'($urandom_range(0, 7));
            if (rc == 3'b110 && $urandom_range(0, 3) != 0) rc = 3'b100;
            step("rand", rc, 16'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
